// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
// Master IDs are carried through the response-routing FIFO.
package mem_arb_pkg;

   localparam int NUM_MASTERS = 2;

   typedef logic [0:0] master_id_t;

   localparam master_id_t ID_M0 = 1'b0;
   localparam master_id_t ID_M1 = 1'b1;

   // With two masters the round-robin successor is simply the other one
   function automatic master_id_t other_id(input master_id_t id);
      return ~id;
   endfunction

endpackage

// File: rtl/id_fifo.sv
// Synchronous FIFO of master IDs recording the issue order of accepted requests.
// The head entry is visible combinationally so responses route with no added latency.
module id_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  master_id_t din_i,
   input  logic       pop_i,
   output master_id_t head_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   master_id_t    mem_reg [DEPTH];

   logic push_ok;
   logic pop_ok;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      if (p == AW'(DEPTH - 1)) begin
         return '0;
      end
      return p + AW'(1);
   endfunction

   assign full_o  = (count_reg == CW'(DEPTH));
   assign empty_o = (count_reg == '0);
   assign head_o  = mem_reg[rd_ptr_reg];

   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (pop_ok) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage needs no reset: entries are only read behind a valid count
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= din_i;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid slave port between two masters,
// routing each response back to its issuer in acceptance order.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    m0_req_i,
   output logic                    m0_gnt_o,
   output logic                    m0_rvalid_o,
   input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
   input  logic                    m0_we_i,
   input  logic [DATA_WIDTH/8-1:0] m0_be_i,
   input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
   output logic [DATA_WIDTH-1:0]   m0_rdata_o,
   input  logic                    m1_req_i,
   output logic                    m1_gnt_o,
   output logic                    m1_rvalid_o,
   input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
   input  logic                    m1_we_i,
   input  logic [DATA_WIDTH/8-1:0] m1_be_i,
   input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
   output logic [DATA_WIDTH-1:0]   m1_rdata_o,
   output logic                    s_req_o,
   input  logic                    s_gnt_i,
   input  logic                    s_rvalid_i,
   output logic [ADDR_WIDTH-1:0]   s_addr_o,
   output logic                    s_we_o,
   output logic [DATA_WIDTH/8-1:0] s_be_o,
   output logic [DATA_WIDTH-1:0]   s_wdata_o,
   input  logic [DATA_WIDTH-1:0]   s_rdata_i,
   output logic                    err_o
);

   logic       lock_reg, lock_next;
   master_id_t lock_id_reg, lock_id_next;
   master_id_t prio_reg, prio_next;
   logic       err_reg, err_next;

   master_id_t sel_id;
   logic       sel_req;
   logic       accept;
   logic       fifo_full, fifo_empty, fifo_pop;
   master_id_t head_id;

   logic [NUM_MASTERS-1:0] req_vec;
   logic [NUM_MASTERS-1:0] gnt_vec;
   logic [NUM_MASTERS-1:0] rvalid_vec;

   assign req_vec = {m1_req_i, m0_req_i};

   // A pending ungranted request pins the selection so slave fields stay stable
   always_comb begin
      sel_id = ID_M0;
      if (lock_reg) begin
         sel_id = lock_id_reg;
      end else if (m0_req_i && m1_req_i) begin
         sel_id = prio_reg;
      end else if (m1_req_i) begin
         sel_id = ID_M1;
      end
   end

   assign sel_req  = req_vec[sel_id];
   assign s_req_o  = rst_ni & sel_req & ~fifo_full;
   assign accept   = s_req_o & s_gnt_i;
   assign fifo_pop = rst_ni & s_rvalid_i & ~fifo_empty;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_route
         assign gnt_vec[gi]    = accept && (sel_id == master_id_t'(gi));
         assign rvalid_vec[gi] = fifo_pop && (head_id == master_id_t'(gi));
      end
   endgenerate

   assign m0_gnt_o    = gnt_vec[ID_M0];
   assign m1_gnt_o    = gnt_vec[ID_M1];
   assign m0_rvalid_o = rvalid_vec[ID_M0];
   assign m1_rvalid_o = rvalid_vec[ID_M1];
   assign m0_rdata_o  = s_rdata_i;
   assign m1_rdata_o  = s_rdata_i;

   always_comb begin
      s_addr_o  = m0_addr_i;
      s_we_o    = m0_we_i;
      s_be_o    = m0_be_i;
      s_wdata_o = m0_wdata_i;
      if (sel_id == ID_M1) begin
         s_addr_o  = m1_addr_i;
         s_we_o    = m1_we_i;
         s_be_o    = m1_be_i;
         s_wdata_o = m1_wdata_i;
      end
   end

   always_comb begin
      lock_next    = lock_reg;
      lock_id_next = lock_id_reg;
      prio_next    = prio_reg;
      if (accept) begin
         lock_next = 1'b0;
         prio_next = other_id(sel_id);
      end else if (s_req_o) begin
         lock_next    = 1'b1;
         lock_id_next = sel_id;
      end else if (lock_reg && !sel_req) begin
         // Locked master withdrew its request; release rather than wedge
         lock_next = 1'b0;
      end
   end

   assign err_next = err_reg | (s_rvalid_i & fifo_empty);
   assign err_o    = err_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_reg    <= 1'b0;
         lock_id_reg <= ID_M0;
         prio_reg    <= ID_M0;
         err_reg     <= 1'b0;
      end else begin
         lock_reg    <= lock_next;
         lock_id_reg <= lock_id_next;
         prio_reg    <= prio_next;
         err_reg     <= err_next;
      end
   end

   id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (accept),
      .din_i   (sel_id),
      .pop_i   (fifo_pop),
      .head_o  (head_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed master traffic against an sp_ram-like
// slave model with configurable grant stall and response delay.
module tb_mem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;

   logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
   logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
   logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
   logic [3:0]  m0_be_i = 4'hF, m1_be_i = 4'hF;
   logic [31:0] m0_wdata_i = '0, m1_wdata_i = '0;
   logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        s_req_o, s_gnt_i, s_rvalid_i, s_we_o, err_o;
   logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
   logic [3:0]  s_be_o;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(
      .ADDR_WIDTH      (32),
      .DATA_WIDTH      (32),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .m0_req_i    (m0_req_i),
      .m0_gnt_o    (m0_gnt_o),
      .m0_rvalid_o (m0_rvalid_o),
      .m0_addr_i   (m0_addr_i),
      .m0_we_i     (m0_we_i),
      .m0_be_i     (m0_be_i),
      .m0_wdata_i  (m0_wdata_i),
      .m0_rdata_o  (m0_rdata_o),
      .m1_req_i    (m1_req_i),
      .m1_gnt_o    (m1_gnt_o),
      .m1_rvalid_o (m1_rvalid_o),
      .m1_addr_i   (m1_addr_i),
      .m1_we_i     (m1_we_i),
      .m1_be_i     (m1_be_i),
      .m1_wdata_i  (m1_wdata_i),
      .m1_rdata_o  (m1_rdata_o),
      .s_req_o     (s_req_o),
      .s_gnt_i     (s_gnt_i),
      .s_rvalid_i  (s_rvalid_i),
      .s_addr_o    (s_addr_o),
      .s_we_o      (s_we_o),
      .s_be_o      (s_be_o),
      .s_wdata_o   (s_wdata_o),
      .s_rdata_i   (s_rdata_i),
      .err_o       (err_o)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } cmd_t;

   typedef struct {
      int          id;
      logic [31:0] val;
   } exp_t;

   cmd_t q0[$];
   cmd_t q1[$];
   exp_t exp_gnt_q[$];
   exp_t exp_rsp_q[$];

   int n_total = 0;
   int n_pass  = 0;

   // ---------------- slave model (sp_ram-like) ----------------
   bit          gnt_en = 1'b1;
   int          rsp_delay = 1;
   bit          spur_req = 1'b0;
   logic        spur_q = 1'b0;
   logic [7:0]  pv = '0;
   logic [31:0] pd [8];
   logic [31:0] ram [64];

   assign s_gnt_i    = s_req_o & gnt_en;
   assign s_rvalid_i = pv[0] | spur_q;
   assign s_rdata_i  = spur_q ? 32'h0000_0BAD : pd[0];

   always @(posedge clk_i) begin
      for (int i = 0; i < 7; i++) begin
         pv[i] <= pv[i+1];
         pd[i] <= pd[i+1];
      end
      pv[7] <= 1'b0;
      spur_q <= spur_req;
      if (rst_ni && s_req_o && s_gnt_i) begin
         pv[rsp_delay-1] <= 1'b1;
         if (s_we_o) begin
            pd[rsp_delay-1] <= '0;
            for (int b = 0; b < 4; b++) begin
               if (s_be_o[b]) ram[s_addr_o[7:2]][b*8 +: 8] <= s_wdata_o[b*8 +: 8];
            end
         end else begin
            pd[rsp_delay-1] <= ram[s_addr_o[7:2]];
         end
      end
   end

   // ---------------- master drivers ----------------
   bit g0_seen = 1'b0;
   bit g1_seen = 1'b0;

   always @(negedge clk_i) begin
      g0_seen = m0_gnt_o;
      g1_seen = m1_gnt_o;
   end

   always @(posedge clk_i) begin
      #1;
      if (g0_seen && q0.size() != 0) void'(q0.pop_front());
      if (g1_seen && q1.size() != 0) void'(q1.pop_front());
      m0_req_i = (q0.size() != 0);
      m1_req_i = (q1.size() != 0);
      if (q0.size() != 0) begin
         m0_addr_i  = q0[0].addr;
         m0_we_i    = q0[0].we;
         m0_wdata_i = q0[0].wdata;
      end
      if (q1.size() != 0) begin
         m1_addr_i  = q1[0].addr;
         m1_we_i    = q1[0].we;
         m1_wdata_i = q1[0].wdata;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
   endtask

   // Calls must follow the hand-computed global grant order
   task automatic issue(input int id, input logic [31:0] addr, input logic we,
                        input logic [31:0] wdata, input logic [31:0] rsp);
      cmd_t c;
      exp_t e;
      c.addr = addr;
      c.we = we;
      c.wdata = wdata;
      if (id == 0) q0.push_back(c);
      else q1.push_back(c);
      e.id = id;
      e.val = addr;
      exp_gnt_q.push_back(e);
      e.val = rsp;
      exp_rsp_q.push_back(e);
   endtask

   exp_t mon_e;

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (m0_gnt_o && m1_gnt_o) begin
            n_total++;
            $display("FAIL dual_gnt: actual=both required=one");
         end else if (m0_gnt_o || m1_gnt_o) begin
            if (exp_gnt_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_gnt: actual=m%0d addr=0x%08h required=none", m1_gnt_o, s_addr_o);
            end else begin
               mon_e = exp_gnt_q.pop_front();
               chk("gnt_id", {31'b0, m1_gnt_o}, 32'(mon_e.id));
               chk("gnt_addr", s_addr_o, mon_e.val);
               $display("gnt  m%0d addr=0x%08h", m1_gnt_o, s_addr_o);
            end
         end
         if (m0_rvalid_o && m1_rvalid_o) begin
            n_total++;
            $display("FAIL dual_rvalid: actual=both required=one");
         end else if (m0_rvalid_o || m1_rvalid_o) begin
            if (exp_rsp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_rvalid: actual=m%0d required=none", m1_rvalid_o);
            end else begin
               mon_e = exp_rsp_q.pop_front();
               chk("rsp_id", {31'b0, m1_rvalid_o}, 32'(mon_e.id));
               chk("rsp_data", m1_rvalid_o ? m1_rdata_o : m0_rdata_o, mon_e.val);
               $display("rsp  m%0d data=0x%08h", m1_rvalid_o, m1_rvalid_o ? m1_rdata_o : m0_rdata_o);
            end
         end
      end
   end

   task automatic drain();
      int k;
      k = 0;
      while ((q0.size() != 0 || q1.size() != 0 || exp_gnt_q.size() != 0 ||
              exp_rsp_q.size() != 0) && k < 60) begin
         @(negedge clk_i);
         k++;
      end
      chk("drain_done", {31'b0, (k < 60)}, 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      for (int i = 0; i < 64; i++) ram[i] = '0;
      ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;
      ram[4] = 32'h55; ram[5] = 32'h66; ram[6] = 32'h77; ram[7] = 32'h88;
      ram[8] = 32'h99;

      // Reset held while both masters request; contention traffic follows release
      issue(0, 32'h0, 1'b0, '0, 32'h11);
      issue(1, 32'h4, 1'b0, '0, 32'h22);
      issue(0, 32'h8, 1'b0, '0, 32'h33);
      issue(1, 32'hC, 1'b0, '0, 32'h44);
      repeat (3) @(negedge clk_i);
      chk("rst_s_req", {31'b0, s_req_o}, 32'd0);
      chk("rst_m0_gnt", {31'b0, m0_gnt_o}, 32'd0);
      chk("rst_m1_gnt", {31'b0, m1_gnt_o}, 32'd0);
      chk("rst_rvalid", {30'b0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
      chk("rst_err", {31'b0, err_o}, 32'd0);
      @(posedge clk_i); #2 rst_ni = 1'b1;
      drain();

      // Slave stall with m1 selected; m0 arrives mid-stall with priority on its side
      @(posedge clk_i); #2;
      gnt_en = 1'b0;
      issue(1, 32'h10, 1'b0, '0, 32'h55);
      @(negedge clk_i);
      @(negedge clk_i);
      chk("stall_addr0", s_addr_o, 32'h10);
      chk("stall_s_req", {31'b0, s_req_o}, 32'd1);
      chk("stall_m1_gnt", {31'b0, m1_gnt_o}, 32'd0);
      issue(0, 32'h14, 1'b0, '0, 32'h66);
      @(negedge clk_i);
      chk("stall_addr1", s_addr_o, 32'h10);
      @(negedge clk_i);
      chk("stall_addr2", s_addr_o, 32'h10);
      chk("stall_m0_gnt", {31'b0, m0_gnt_o}, 32'd0);
      @(posedge clk_i); #2 gnt_en = 1'b1;
      drain();

      // Outstanding limit: responses delayed 4 cycles, FIFO depth 2
      @(posedge clk_i); #2;
      rsp_delay = 4;
      issue(1, 32'h1C, 1'b0, '0, 32'h88);
      issue(0, 32'h18, 1'b0, '0, 32'h77);
      issue(0, 32'h20, 1'b0, '0, 32'h99);
      @(negedge clk_i);
      @(negedge clk_i);
      @(negedge clk_i);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("full_s_req_low", {31'b0, s_req_o}, 32'd0);
      end
      @(negedge clk_i);
      chk("full_s_req_reassert", {31'b0, s_req_o}, 32'd1);
      drain();
      rsp_delay = 1;

      // Single master back-to-back reads
      @(posedge clk_i); #2;
      issue(0, 32'h0, 1'b0, '0, 32'h11);
      issue(0, 32'h4, 1'b0, '0, 32'h22);
      issue(0, 32'h8, 1'b0, '0, 32'h33);
      @(negedge clk_i);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("b2b_m0_gnt", {31'b0, m0_gnt_o}, 32'd1);
      end
      drain();

      // Write then read back through m1
      @(posedge clk_i); #2;
      issue(1, 32'h24, 1'b1, 32'hDEAD_BEEF, 32'h0);
      issue(1, 32'h24, 1'b0, '0, 32'hDEAD_BEEF);
      drain();
      chk("err_clean", {31'b0, err_o}, 32'd0);

      // Spurious response with nothing outstanding
      @(posedge clk_i); #2 spur_req = 1'b1;
      @(posedge clk_i); #2 spur_req = 1'b0;
      @(negedge clk_i);
      chk("spur_rvalid", {30'b0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
      @(negedge clk_i);
      chk("spur_err_set", {31'b0, err_o}, 32'd1);
      repeat (3) @(negedge clk_i);
      chk("spur_err_sticky", {31'b0, err_o}, 32'd1);
      rst_ni = 1'b0;
      #1;
      chk("err_cleared_by_rst", {31'b0, err_o}, 32'd0);
      chk("rst2_s_req", {31'b0, s_req_o}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
